alu_datamem_decoder: RTL and testbench
======================================

ALU_DATAMEM_DECODER -- requirements
Module: alu_datamem_decoder

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 1024, data-memory depth in 32-bit words; power of two.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 instr  in  32  current instruction word.
REQ-006 rs_data / rt_data  in  32 each  register-file read data for rs / rt.
REQ-007 pc_plus4  in  32  PC+4, used as link value.
REQ-008 rs_addr / rt_addr  out  5 each  instr[25:21] / instr[20:16].
REQ-009 reg_wr  out  1  register write enable; reg_waddr  out  5  write register.
REQ-010 wb_data  out  32  register write-back data.
REQ-011 alu_result  out  32; carryout, zero, overflow  out  1 each  ALU flags.
REQ-012 pc_sel  out  2  00 PC+4, 01 branch, 10 jump (instr[25:0]), 11 jump-register (rs_data).
REQ-013 imm_ext  out  32  extended immediate; illegal  out  1  sticky illegal-instruction flag.

Function
REQ-014 Decode SHALL be combinational: ADDI 0x08, XORI 0x0E, LW 0x23, SW 0x2B, BNE 0x05, J 0x02, JAL 0x03, R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
REQ-015 imm_ext SHALL be sign-extended instr[15:0] for ADDI/LW/SW/BNE, zero-extended for XORI.
REQ-016 ALU operand A = rs_data; operand B = imm_ext for ADDI/XORI/LW/SW, else rt_data.
REQ-017 ALU ops: ADD (ADDI/ADD/LW/SW), SUB (SUB/BNE), XOR (XORI), SLT (SLT); result is 32-bit, wraps modulo 2^32.
REQ-018 SLT SHALL return 1 iff A<B signed, correct even when A-B overflows.
REQ-019 carryout = bit-32 carry for ADD, NOT borrow for SUB (A+~B+1); overflow = signed overflow for ADD/SUB; both 0 for XOR/SLT.
REQ-020 zero SHALL be 1 iff alu_result==0, all ops.
REQ-021 reg_wr=1 for ADDI, XORI, LW, ADD, SUB, SLT, JAL; 0 for SW, BNE, J, JR, illegal.
REQ-022 reg_waddr = rd (instr[15:11]) for R-type, 31 for JAL, else rt.
REQ-023 wb_data = memory read data for LW, pc_plus4 for JAL, else alu_result.
REQ-024 Data memory: word index alu_result[log2(DMEM_WORDS)+1:2], upper/lower bits ignored; asynchronous read; write of rt_data on rising clk when SW decoded and rst_n=1.
REQ-025 Read of the address written in the same cycle SHALL return old data until after the edge.
REQ-026 pc_sel = 01 for BNE when zero=0, 00 for BNE when zero=1; 10 for J/JAL; 11 for JR; 00 otherwise.
REQ-027 Unknown opcode/funct: all write enables 0, pc_sel 00; illegal SHALL set on the next rising edge and stay set until reset.

Reset
REQ-028 While rst_n=0 at a rising edge, illegal SHALL clear to 0 and no memory write SHALL occur; reg_wr SHALL be forced 0 while rst_n=0.
REQ-029 Memory contents SHALL be retained through reset; content after power-up is undefined.
REQ-030 Combinational outputs other than reg_wr SHALL follow instr regardless of rst_n.

Configuration
REQ-031 Macro JAL_LINK_EN defined: JAL decoded per REQ-021..026; undefined: opcode 0x03 SHALL be treated as illegal (REQ-027).

Verification
REQ-032 ADDI rs_data=0, imm=5 -> alu_result=5, reg_wr=1, reg_waddr=rt, wb_data=5.
REQ-033 ADD rs=0x7FFFFFFF, rt=1 -> result 0x80000000, overflow=1, carryout=0; SUB 5-5 -> zero=1, carryout=1.
REQ-034 SLT rs=0x80000000, rt=1 -> result 1; XORI rs=0xFFFF0000, imm=0x8001 -> 0xFFFF8001.
REQ-035 SW rt=0xDEADBEEF to addr 8, then LW addr 8 -> wb_data=0xDEADBEEF; SW with rst_n=0 -> memory unchanged.
REQ-036 BNE unequal -> pc_sel=01; equal -> 00; JAL pc_plus4=0x104 -> reg_waddr=31, wb_data=0x104, pc_sel=10.
REQ-037 Opcode 0x3F -> reg_wr=0, illegal=1 after edge and held; rst_n=0 edge -> illegal=0.

Source files
------------

// File: rtl/alu_datamem_decoder.sv
// Single-cycle MIPS-subset decode, ALU, data memory and link/branch select.
// Optional macro JAL_LINK_EN enables JAL; without it opcode 0x03 decodes as illegal.
module alu_datamem_decoder #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] pc_plus4,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        reg_wr,
  output logic [4:0]  reg_waddr,
  output logic [31:0] wb_data,
  output logic [31:0] alu_result,
  output logic        carryout,
  output logic        zero,
  output logic        overflow,
  output logic [1:0]  pc_sel,
  output logic [31:0] imm_ext,
  output logic        illegal
);
  localparam int AW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_XOR, OP_SLT} alu_op_t;

  logic [5:0]  opcode, funct;
  logic        is_r, is_add, is_sub, is_slt, is_jr;
  logic        is_addi, is_xori, is_lw, is_sw, is_bne, is_j, is_jal;
  logic        bad;
  alu_op_t     op;
  logic [31:0] b, bx;
  logic        cin;
  logic [32:0] sum;
  logic [AW-1:0] widx;
  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] rdata;

  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];

  assign is_r    = (opcode == 6'h00);
  assign is_add  = is_r && (funct == 6'h20);
  assign is_sub  = is_r && (funct == 6'h22);
  assign is_slt  = is_r && (funct == 6'h2A);
  assign is_jr   = is_r && (funct == 6'h08);
  assign is_addi = (opcode == 6'h08);
  assign is_xori = (opcode == 6'h0E);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_bne  = (opcode == 6'h05);
  assign is_j    = (opcode == 6'h02);
`ifdef JAL_LINK_EN
  assign is_jal  = (opcode == 6'h03);
`else
  assign is_jal  = 1'b0;
`endif

  assign bad = !(is_add || is_sub || is_slt || is_jr || is_addi || is_xori ||
                 is_lw || is_sw || is_bne || is_j || is_jal);

  assign imm_ext = is_xori ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
  assign b       = (is_addi || is_xori || is_lw || is_sw) ? imm_ext : rt_data;

  always_comb begin
    op = OP_ADD;
    if (is_sub || is_bne) op = OP_SUB;
    else if (is_xori)     op = OP_XOR;
    else if (is_slt)      op = OP_SLT;
  end

  // Subtraction runs through the adder as A + ~B + 1, so carryout is NOT borrow.
  assign bx  = (op == OP_SUB) ? ~b : b;
  assign cin = (op == OP_SUB);
  assign sum = {1'b0, rs_data} + {1'b0, bx} + {32'h0, cin};

  always_comb begin
    alu_result = sum[31:0];
    carryout   = sum[32];
    overflow   = (rs_data[31] == bx[31]) && (sum[31] != rs_data[31]);
    case (op)
      OP_XOR: begin
        alu_result = rs_data ^ b;
        carryout   = 1'b0;
        overflow   = 1'b0;
      end
      OP_SLT: begin
        alu_result = {31'h0, $signed(rs_data) < $signed(b)};
        carryout   = 1'b0;
        overflow   = 1'b0;
      end
      default: ;
    endcase
  end

  assign zero = (alu_result == 32'h0);

  assign widx  = alu_result[AW+1:2];
  assign rdata = mem[widx];

  always_ff @(posedge clk) begin
    if (rst_n && is_sw) mem[widx] <= rt_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   illegal <= 1'b0;
    else if (bad) illegal <= 1'b1;
  end

  assign reg_wr = rst_n && (is_addi || is_xori || is_lw || is_add || is_sub ||
                            is_slt || is_jal);

  always_comb begin
    reg_waddr = instr[20:16];
    if (is_r)        reg_waddr = instr[15:11];
    else if (is_jal) reg_waddr = 5'd31;
  end

  always_comb begin
    wb_data = alu_result;
    if (is_lw)       wb_data = rdata;
    else if (is_jal) wb_data = pc_plus4;
  end

  always_comb begin
    pc_sel = 2'b00;
    if (is_bne && !zero)   pc_sel = 2'b01;
    else if (is_j || is_jal) pc_sel = 2'b10;
    else if (is_jr)        pc_sel = 2'b11;
  end
endmodule

// File: tb/tb_alu_datamem_decoder.sv
// Directed-vector bench for alu_datamem_decoder; JAL expectations follow JAL_LINK_EN.
module tb_alu_datamem_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, rs_data, rt_data, pc_plus4;
  logic [4:0]  rs_addr, rt_addr, reg_waddr;
  logic        reg_wr, carryout, zero, overflow, illegal;
  logic [31:0] wb_data, alu_result, imm_ext;
  logic [1:0]  pc_sel;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_datamem_decoder #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .pc_plus4(pc_plus4), .rs_addr(rs_addr), .rt_addr(rt_addr), .reg_wr(reg_wr),
    .reg_waddr(reg_waddr), .wb_data(wb_data), .alu_result(alu_result),
    .carryout(carryout), .zero(zero), .overflow(overflow), .pc_sel(pc_sel),
    .imm_ext(imm_ext), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h0, fn};
  endfunction

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc_plus4 = 32'h0;
    rs_data = 32'h0; rt_data = 32'h0;
    instr = enc_i(6'h08, 5'd3, 5'd7, 16'd5);
    edge1; edge1;
    chk("rst_illegal", illegal, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_alu_follows", alu_result, 32'd5);

    rst_n = 1'b1; #1;
    chk("addi_alu", alu_result, 32'd5);
    chk("addi_wr", reg_wr, 1);
    chk("addi_waddr", reg_waddr, 7);
    chk("addi_wb", wb_data, 32'd5);
    chk("addi_rs_addr", rs_addr, 3);
    chk("addi_rt_addr", rt_addr, 7);
    chk("addi_pc_sel", pc_sel, 0);

    instr = enc_i(6'h08, 5'd1, 5'd2, 16'hFFFF); rs_data = 32'd0; #1;
    chk("addi_sext", imm_ext, 32'hFFFFFFFF);
    chk("addi_neg", alu_result, 32'hFFFFFFFF);

    instr = enc_r(5'd1, 5'd2, 5'd9, 6'h20); rs_data = 32'h7FFFFFFF; rt_data = 32'd1; #1;
    chk("add_res", alu_result, 32'h80000000);
    chk("add_ovf", overflow, 1);
    chk("add_cout", carryout, 0);
    chk("add_waddr", reg_waddr, 9);

    rs_data = 32'hFFFFFFFF; rt_data = 32'd1; #1;
    chk("add_wrap", alu_result, 32'h0);
    chk("add_wrap_cout", carryout, 1);
    chk("add_wrap_zero", zero, 1);

    instr = enc_r(5'd1, 5'd2, 5'd4, 6'h22); rs_data = 32'd5; rt_data = 32'd5; #1;
    chk("sub_zero", zero, 1);
    chk("sub_cout", carryout, 1);
    chk("sub_ovf", overflow, 0);

    rs_data = 32'd3; rt_data = 32'd5; #1;
    chk("sub_neg", alu_result, 32'hFFFFFFFE);
    chk("sub_borrow", carryout, 0);

    instr = enc_r(5'd1, 5'd2, 5'd5, 6'h2A); rs_data = 32'h80000000; rt_data = 32'd1; #1;
    chk("slt_ovfcase", alu_result, 32'd1);
    chk("slt_flags", {carryout, overflow}, 0);
    rs_data = 32'h7FFFFFFF; rt_data = 32'hFFFFFFFF; #1;
    chk("slt_false", alu_result, 32'd0);
    chk("slt_zero", zero, 1);

    instr = enc_i(6'h0E, 5'd1, 5'd6, 16'h8001); rs_data = 32'hFFFF0000; #1;
    chk("xori_zext", imm_ext, 32'h00008001);
    chk("xori_res", alu_result, 32'hFFFF8001);
    chk("xori_wr", reg_wr, 1);

    // Store then load through the same and an aliased address.
    instr = enc_i(6'h2B, 5'd1, 5'd2, 16'd8); rs_data = 32'd0; rt_data = 32'hDEADBEEF; #1;
    chk("sw_wr", reg_wr, 0);
    chk("sw_addr", alu_result, 32'd8);
    edge1;
    instr = enc_i(6'h23, 5'd1, 5'd2, 16'd8); rt_data = 32'h0; #1;
    chk("lw_wb", wb_data, 32'hDEADBEEF);
    chk("lw_wr", reg_wr, 1);
    rs_data = 32'h00001000; #1;
    chk("lw_alias", wb_data, 32'hDEADBEEF);

    instr = enc_i(6'h2B, 5'd1, 5'd2, 16'd8); rs_data = 32'd0; rt_data = 32'h12345678;
    rst_n = 1'b0;
    edge1;
    rst_n = 1'b1;
    instr = enc_i(6'h23, 5'd1, 5'd2, 16'd8); #1;
    chk("sw_in_reset", wb_data, 32'hDEADBEEF);

    instr = enc_i(6'h05, 5'd1, 5'd2, 16'hFFFC); rs_data = 32'd1; rt_data = 32'd2; #1;
    chk("bne_taken", pc_sel, 2'b01);
    chk("bne_wr", reg_wr, 0);
    rt_data = 32'd1; #1;
    chk("bne_not", pc_sel, 2'b00);

    instr = {6'h02, 26'h0000100}; #1;
    chk("j_pc_sel", pc_sel, 2'b10);
    chk("j_wr", reg_wr, 0);

    instr = enc_r(5'd31, 5'd0, 5'd0, 6'h08); #1;
    chk("jr_pc_sel", pc_sel, 2'b11);
    chk("jr_wr", reg_wr, 0);
    edge1;
    chk("legal_no_illegal", illegal, 0);

    instr = {6'h3F, 26'h0}; #1;
    chk("ill_wr", reg_wr, 0);
    chk("ill_pc_sel", pc_sel, 0);
    chk("ill_pre_edge", illegal, 0);
    edge1;
    chk("ill_set", illegal, 1);
    instr = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    edge1;
    chk("ill_held", illegal, 1);
    rst_n = 1'b0;
    edge1;
    chk("ill_cleared", illegal, 0);
    rst_n = 1'b1;

    instr = enc_r(5'd1, 5'd2, 5'd3, 6'h3F); #1;
    chk("bad_funct_wr", reg_wr, 0);
    edge1;
    chk("bad_funct_ill", illegal, 1);
    rst_n = 1'b0; edge1; rst_n = 1'b1;

    instr = {6'h03, 26'h0000040}; pc_plus4 = 32'h104; #1;
`ifdef JAL_LINK_EN
    chk("jal_waddr", reg_waddr, 31);
    chk("jal_wb", wb_data, 32'h104);
    chk("jal_pc_sel", pc_sel, 2'b10);
    chk("jal_wr", reg_wr, 1);
    edge1;
    chk("jal_legal", illegal, 0);
`else
    chk("jal_off_wr", reg_wr, 0);
    chk("jal_off_pc_sel", pc_sel, 2'b00);
    edge1;
    chk("jal_off_ill", illegal, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
